// File: rtl/led_blink_scheduler_pkg.sv
// Shared definitions for the status-LED blink scheduler.
// Covers state encoding, requester count, blink-count width and the round-robin pick.
package led_blink_scheduler_pkg;

  localparam int NREQ  = 3;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ON   = 3'd1,
    ST_OFF  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // First requesting index scanning upward from last+1, wrapping modulo NREQ.
  function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req, input logic [1:0] last);
    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;
    pick  = last;
    cand  = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = 2'((int'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/led_blink_scheduler_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks.
// The clr input restarts the count so that a new phase starts on a tick boundary.
module led_tick_gen #(
  parameter int TICK_DIV = 12000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div_q, div_d;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q + 1'b1;
    if (clr || tick) div_d = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) div_q <= '0;
    else     div_q <= div_d;
  end

endmodule

// File: rtl/led_blink_scheduler.sv
// Round-robin sharing of the status LED among three burst-blink requesters.
//   state | meaning
//   IDLE  | no owner; arbitrate among pending requests
//   ON    | LED[0] lit for ON_TICKS ticks
//   OFF   | LED[0] dark for OFF_TICKS ticks between blinks
//   GAP   | LED[0] dark for GAP_TICKS ticks after the last blink
//   DONE  | one-cycle done pulse to the owner, then release
module led_blink_scheduler
  import led_blink_scheduler_pkg::*;
#(
  parameter int TICK_DIV  = 12000000,
  parameter int ON_TICKS  = 1,
  parameter int OFF_TICKS = 1,
  parameter int GAP_TICKS = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*CNT_W-1:0]   blinks,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [1:0]              LED
);

  localparam int PMAX_OG = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int PMAX    = (PMAX_OG > GAP_TICKS) ? PMAX_OG : GAP_TICKS;
  localparam int PW      = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam logic [PW-1:0] ON_LD  = PW'(ON_TICKS - 1);
  localparam logic [PW-1:0] OFF_LD = PW'(OFF_TICKS - 1);
  localparam logic [PW-1:0] GAP_LD = PW'(GAP_TICKS - 1);

  state_e             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [1:0]         last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      phase_q, phase_d;
  logic [1:0]         pick;
  logic [CNT_W-1:0]   cnt_new;
  logic               tick, clr, phase_end, req_held;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (clr),
    .tick (tick)
  );

  assign pick      = rr_pick(req, last_q);
  assign cnt_new   = blinks[CNT_W*pick +: CNT_W];
  assign req_held  = req[last_q];
  assign phase_end = tick && (phase_q == '0);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    clr     = 1'b0;
    if (tick && phase_q != '0) phase_d = phase_q - 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          last_d      = pick;
          cnt_d       = cnt_new;
          clr         = 1'b1;
          if (cnt_new == '0) begin
            state_d = ST_GAP;
            phase_d = GAP_LD;
          end else begin
            state_d = ST_ON;
            phase_d = ON_LD;
          end
        end
      end
      ST_ON: begin
        if (!req_held) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (phase_end) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q != CNT_W'(1)) begin
            state_d = ST_OFF;
            phase_d = OFF_LD;
          end else begin
            state_d = ST_GAP;
            phase_d = GAP_LD;
          end
        end
      end
      ST_OFF: begin
        if (!req_held) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (phase_end) begin
          state_d = ST_ON;
          phase_d = ON_LD;
        end
      end
      ST_GAP: begin
        if (!req_held) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (phase_end) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= 2'd2;
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = (state_q == ST_DONE) ? gnt_q : '0;
  assign busy = (state_q != ST_IDLE);
  assign LED  = {busy, state_q == ST_ON};

endmodule
